// File: rtl/mem_block_responder.sv
// Block-granular main-memory responder: one refill or writeback in flight, fixed latency.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module mem_block_responder #(
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int BLOCK_SIZE     = 128,
  parameter int READ_LATENCY   = 4,
  parameter int WRITE_LATENCY  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_en_mem,
  input  logic                      write_en_mem,
  input  logic [BLK_ADDR_WIDTH-1:0] blk_addr,
  input  logic [BLOCK_SIZE-1:0]     dirty_block_in,
  output logic [BLOCK_SIZE-1:0]     data_out_mem,
  output logic                      done_mem,
  output logic                      busy
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count
`endif
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int DEPTH   = 2 ** BLK_ADDR_WIDTH;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BLK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0]     wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0]     dout_q, dout_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      mem_we_s;

  logic [BLOCK_SIZE-1:0]     mem_q [DEPTH];

  // State, counter, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      addr_q  <= {BLK_ADDR_WIDTH{1'b0}};
      wdata_q <= {BLOCK_SIZE{1'b0}};
      dout_q  <= {BLOCK_SIZE{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: write wins over read in IDLE; requests outside IDLE are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (write_en_mem) begin
          state_d = WR_WAIT;
          cnt_d   = WR_LOAD;
          addr_d  = blk_addr;
          wdata_d = dirty_block_in;
        end else if (read_en_mem) begin
          state_d = RD_WAIT;
          cnt_d   = RD_LOAD;
          addr_d  = blk_addr;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values and the single memory commit point
  always_comb begin
    done_d   = 1'b0;
    busy_d   = 1'b0;
    dout_d   = dout_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: busy_d = write_en_mem | read_en_mem;
      RD_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          done_d = 1'b1;
          dout_d = mem_q[addr_q];
        end else begin
          busy_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          done_d   = 1'b1;
          mem_we_s = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      RESP:    busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // Line storage; contents survive reset, an aborting reset blocks the commit
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign data_out_mem = dout_q;
  assign done_mem     = done_q;
  assign busy         = busy_q;

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;
  logic        rd_done_s, wr_done_s;

  assign rd_done_s = (state_q == RD_WAIT) && (cnt_q == CNT_ZERO);
  assign wr_done_s = (state_q == WR_WAIT) && (cnt_q == CNT_ZERO);

  // Saturating completion counters, updated on the edge that raises done_mem
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (rd_done_s && (rd_count_q != 32'hFFFF_FFFF)) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (wr_done_s && (wr_count_q != 32'hFFFF_FFFF)) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Table-driven cycle-by-cycle bench for mem_block_responder (default latencies 4/4).
module tb_mem_block_responder;

  localparam int AW = 10;
  localparam int BW = 128;
  localparam int RL = 4;
  localparam int WL = 4;

  logic          clk;
  logic          rst;
  logic          read_en_mem;
  logic          write_en_mem;
  logic [AW-1:0] blk_addr;
  logic [BW-1:0] dirty_block_in;
  logic [BW-1:0] data_out_mem;
  logic          done_mem;
  logic          busy;
`ifdef MEM_STATS_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  mem_block_responder #(
    .BLK_ADDR_WIDTH(AW),
    .BLOCK_SIZE    (BW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .read_en_mem   (read_en_mem),
    .write_en_mem  (write_en_mem),
    .blk_addr      (blk_addr),
    .dirty_block_in(dirty_block_in),
    .data_out_mem  (data_out_mem),
    .done_mem      (done_mem),
    .busy          (busy)
`ifdef MEM_STATS_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] din;
    logic          done;
    logic          busy;
    logic [BW-1:0] dout;
  } vec_t;

  vec_t          vecs[$];
  logic [BW-1:0] m_dout;
  int            tests = 0;
  int            fails = 0;

  localparam logic [BW-1:0] P1   = {4{32'h1111_0001}};
  localparam logic [BW-1:0] P2   = {4{32'h2222_0002}};
  localparam logic [BW-1:0] P3   = {4{32'h3333_0003}};
  localparam logic [BW-1:0] D1   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [BW-1:0] A5   = {16{8'hA5}};
  localparam logic [BW-1:0] ONES = {BW{1'b1}};
  localparam logic [BW-1:0] DEAD = {4{32'hDEAD_BEEF}};
  localparam logic [BW-1:0] ZERO = {BW{1'b0}};

  // Expected data_out_mem is whatever m_dout holds when the vector is added
  task automatic add(input logic r, input logic rd, input logic wr, input logic [AW-1:0] a,
                     input logic [BW-1:0] d, input logic dn, input logic bz);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.din = d;
    v.done = dn; v.busy = bz; v.dout = m_dout;
    vecs.push_back(v);
  endtask

  task automatic t_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    repeat (WL) add(1'b0, 1'b0, 1'b1, a, d, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, a, d, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, a, d, 1'b0, 1'b0);
  endtask

  task automatic t_read(input logic [AW-1:0] a, input logic [BW-1:0] exp_d);
    repeat (RL) add(1'b0, 1'b1, 1'b0, a, ZERO, 1'b0, 1'b1);
    m_dout = exp_d;
    add(1'b0, 1'b1, 1'b0, a, ZERO, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, a, ZERO, 1'b0, 1'b0);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      read_en_mem    = vecs[i].rd;
      write_en_mem   = vecs[i].wr;
      blk_addr       = vecs[i].addr;
      dirty_block_in = vecs[i].din;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (done_mem !== vecs[i].done) begin
        fails++;
        $display("FAIL %s[%0d] done_mem: got %b expected %b", tag, i, done_mem, vecs[i].done);
      end
      tests++;
      if (busy !== vecs[i].busy) begin
        fails++;
        $display("FAIL %s[%0d] busy: got %b expected %b", tag, i, busy, vecs[i].busy);
      end
      tests++;
      if (data_out_mem !== vecs[i].dout) begin
        fails++;
        $display("FAIL %s[%0d] data_out_mem: got %h expected %h", tag, i, data_out_mem, vecs[i].dout);
      end
    end
  endtask

  initial begin
    rst = 1'b1; read_en_mem = 1'b0; write_en_mem = 1'b0;
    blk_addr = '0; dirty_block_in = '0;
    @(negedge clk);

    m_dout = ZERO;
    // Reset held two cycles with requests active, then idle
    add(1'b1, 1'b1, 1'b1, 10'h3FF, ONES, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 10'h001, D1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 10'h000, ZERO, 1'b0, 1'b0);
    // Known contents for later readbacks
    t_write(10'h001, P1);
    t_write(10'h002, P2);
    t_write(10'h003, P3);
    // Write then read
    t_write(10'h005, D1);
    t_read(10'h005, D1);
    // Simultaneous: write first, read held through RESP then accepted
    repeat (WL) add(1'b0, 1'b1, 1'b1, 10'h007, A5, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'h007, A5, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 10'h007, ZERO, 1'b0, 1'b0);
    t_read(10'h007, A5);
    // Write pulse while a read is in flight is dropped
    add(1'b0, 1'b1, 1'b0, 10'h001, ZERO, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 10'h001, ZERO, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 10'h002, ONES, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 10'h001, ZERO, 1'b0, 1'b1);
    m_dout = P1;
    add(1'b0, 1'b1, 1'b0, 10'h001, ZERO, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 10'h001, ZERO, 1'b0, 1'b0);
    t_read(10'h002, P2);
    // Reset at E0+2 of a write to 0x03: no done, no commit, data_out cleared
    add(1'b0, 1'b0, 1'b1, 10'h003, DEAD, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 10'h003, DEAD, 1'b0, 1'b1);
    m_dout = ZERO;
    add(1'b1, 1'b0, 1'b1, 10'h003, DEAD, 1'b0, 1'b0);
    repeat (6) add(1'b0, 1'b0, 1'b0, 10'h003, ZERO, 1'b0, 1'b0);
    t_read(10'h003, P3);
    // Reset at E0+2 of a read: no done, data_out returns to zero
    add(1'b0, 1'b1, 1'b0, 10'h005, ZERO, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 10'h005, ZERO, 1'b0, 1'b1);
    m_dout = ZERO;
    add(1'b1, 1'b1, 1'b0, 10'h005, ZERO, 1'b0, 1'b0);
    repeat (6) add(1'b0, 1'b0, 1'b0, 10'h005, ZERO, 1'b0, 1'b0);
    run_vecs("main");

`ifdef MEM_STATS_EN
    // The aborted read above ended in reset; now 3 writes + 2 reads
    vecs.delete();
    t_write(10'h00A, P1);
    t_write(10'h00B, P2);
    t_write(10'h00C, P3);
    t_read(10'h00A, P1);
    t_read(10'h00B, P2);
    run_vecs("stats");
    tests++;
    if (wr_count !== 32'd3) begin
      fails++;
      $display("FAIL wr_count: got %0d expected 3", wr_count);
    end
    tests++;
    if (rd_count !== 32'd2) begin
      fails++;
      $display("FAIL rd_count: got %0d expected 2", rd_count);
    end
    vecs.delete();
    m_dout = ZERO;
    add(1'b1, 1'b0, 1'b0, 10'h000, ZERO, 1'b0, 1'b0);
    run_vecs("stats_rst");
    tests++;
    if ((wr_count !== 32'd0) || (rd_count !== 32'd0)) begin
      fails++;
      $display("FAIL counts_after_rst: got wr=%0d rd=%0d expected 0 0", wr_count, rd_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Block-granular main-memory responder at the far end of the cache refill/writeback interface.
- Services refill reads: returns a whole BLOCK_SIZE-bit line, which the cache stores.
- Services dirty writebacks: accepts a whole line from the cache.
- Fixed, parameterised latency, modelled by a counter plus FSM. Only one transaction is in flight at a time.

Parameters:
- BLK_ADDR_WIDTH, 10, block address width (tag+index bits); depth = 2**BLK_ADDR_WIDTH, so no out-of-range addresses.
- BLOCK_SIZE, 128, line width in bits.
- READ_LATENCY, 4, cycles from refill acceptance to done; legal range >=1.
- WRITE_LATENCY, 4, cycles from writeback acceptance to done; legal range >=1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- read_en_mem  in  1  refill request; held by requester until done_mem.
- write_en_mem  in  1  writeback request; held by requester until done_mem.
- blk_addr  in  BLK_ADDR_WIDTH  block address; sampled at acceptance.
- dirty_block_in  in  BLOCK_SIZE  writeback line; sampled at acceptance.
- data_out_mem  out  BLOCK_SIZE  refill line.
- done_mem  out  1  one-cycle completion pulse.
- busy  out  1  transaction in flight.

Behaviour:
- Storage: array of 2**BLK_ADDR_WIDTH lines. Contents are NOT cleared by rst.
- Reset values: state=IDLE, counter=0, done_mem=0, busy=0, data_out_mem=0. Latched addr/data are cleared.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE:
  - write_en_mem=1 at edge E0 -> latch blk_addr and dirty_block_in, go to WR_WAIT, cnt<=WRITE_LATENCY-1, busy<=1.
  - Otherwise read_en_mem=1 -> latch blk_addr, go to RD_WAIT, cnt<=READ_LATENCY-1, busy<=1.
  - Write has priority when both requests are high. The read stays pending (requester keeps it asserted) and is accepted later.
- RD_WAIT:
  - cnt!=0: cnt decrements by one per edge.
  - cnt==0 at an edge: data_out_mem<=mem[latched addr], done_mem<=1, busy<=0, go to RESP.
- WR_WAIT:
  - cnt!=0: cnt decrements by one per edge.
  - cnt==0 at an edge: mem[latched addr]<=latched data (commit only here), done_mem<=1, busy<=0, go to RESP.
- Latency: done_mem rises at edge E0+LATENCY (LATENCY=1 -> done at E0+1).
- RESP: done_mem<=0 and go to IDLE. Requests are ignored in this cycle, so the requester has one cycle to drop its request.
  - Earliest next acceptance is E0+LATENCY+2.
- Requests seen in RD_WAIT, WR_WAIT or RESP are ignored. They are not queued and have no side effect.
- data_out_mem holds the last refill line until the next refill completes; writes do not change it.
- Read-after-write to the same address returns the written data, because the commit precedes any later acceptance.
- rst asserted mid-transaction: abort, no memory commit, no done_mem pulse, outputs return to their reset values on the next edge.
- Counter width: $clog2(max(READ_LATENCY,WRITE_LATENCY))+1; no wrap occurs.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[31:0] and wr_count[31:0].
  - Each increments in the cycle done_mem pulses for its transaction type. Both saturate at 0xFFFFFFFF.
  - rst clears both to 0. An aborted transaction does not count.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst for 2 cycles with random request inputs -> done_mem=0, busy=0, data_out_mem=0 throughout and after.
- Write then read: write addr 0x05, data 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 accepted at E0 -> done_mem at E0+4 only.
  - Then read 0x05 accepted at Ea -> done_mem at Ea+4 with data_out_mem equal to that data.
- Simultaneous requests: read+write both high to addr 0x07, data 0xA5 repeated -> write done first.
  - Then read accepted two cycles later; it returns the 0xA5 pattern.
- Request while busy: read 0x01 accepted; two cycles later pulse write 0x02 (data 0xFF..F) for one cycle -> no commit.
  - A subsequent read of 0x02 returns its prior value.
- Reset mid-operation: assert rst at E0+2 of a write to 0x03 -> no done_mem, busy=0, mem[0x03] unchanged on readback.
  - Repeat with a read -> no done_mem, data_out_mem=0.
- MEM_STATS_EN: 3 writes + 2 reads + 1 aborted read -> wr_count=3, rd_count=2. After rst, both are 0.
